// File: rtl/comparator_arbiter_if.sv
// comparator_arbiter_if: request/response bundle shared by the arbiter and its requesters
interface comparator_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*WIDTH-1:0]   req_a;
    logic [NUM_REQ*WIDTH-1:0]   req_b;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [$clog2(NUM_REQ)-1:0] rsp_id;
    logic                       rsp_gt;
    logic                       rsp_eq;
    logic                       rsp_lt;
    logic                       busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt, busy
    );
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt, busy
    );
endinterface

// File: rtl/comparator_arbiter.sv
// comparator_arbiter: round-robin shared comparator; COMPARATOR_ARBITER_SIGNED_EN selects signed compare
module comparator_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input logic clk,
    input logic rst_n,
    comparator_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, COMPARE, RESPOND} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  rr_ptr_q, rr_ptr_d, id_q, id_d, grant_id;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic           gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
    logic           found, a_gt_b, a_lt_b;

`ifdef COMPARATOR_ARBITER_SIGNED_EN
    assign a_gt_b = $signed(a_q) > $signed(b_q);
    assign a_lt_b = $signed(a_q) < $signed(b_q);
`else
    assign a_gt_b = a_q > b_q;
    assign a_lt_b = a_q < b_q;
`endif

    // first valid requester at or after rr_ptr, wrapping past the top index
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && bus.req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                found    = 1'b1;
                grant_id = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        id_d          = id_q;
        a_d           = a_q;
        b_d           = b_q;
        gt_d          = gt_q;
        eq_d          = eq_q;
        lt_d          = lt_q;
        bus.req_ready = '0;
        case (state_q)
            IDLE: if (found) begin
                bus.req_ready[grant_id] = 1'b1;
                id_d    = grant_id;
                a_d     = bus.req_a[grant_id*WIDTH +: WIDTH];
                b_d     = bus.req_b[grant_id*WIDTH +: WIDTH];
                state_d = COMPARE;
            end
            COMPARE: begin
                gt_d    = a_gt_b;
                eq_d    = a_q == b_q;
                lt_d    = a_lt_b;
                state_d = RESPOND;
            end
            RESPOND: if (bus.rsp_ready) begin
                rr_ptr_d = (id_q == IW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                gt_d     = 1'b0;
                eq_d     = 1'b0;
                lt_d     = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            gt_q     <= 1'b0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            gt_q     <= gt_d;
            eq_q     <= eq_d;
            lt_q     <= lt_d;
        end
    end

    assign bus.rsp_valid = state_q == RESPOND;
    assign bus.busy      = state_q != IDLE;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_gt    = gt_q;
    assign bus.rsp_eq    = eq_q;
    assign bus.rsp_lt    = lt_q;
endmodule

// File: tb/tb_comparator_arbiter.sv
// tb_comparator_arbiter: directed stimulus with a queue scoreboard drained by an output monitor
module tb_comparator_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    typedef struct packed {
        logic [1:0] id;
        logic       gt;
        logic       eq;
        logic       lt;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    comparator_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus();
    comparator_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    rsp_t sb[$];
    int   acc_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   gcyc = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s", name);
    endtask

    // monitor: accept-to-valid latency, one-hot grants, and response contents
    always @(negedge clk) begin
        if (!rst_n) begin
            acc_q.delete();
            prev_valid <= 1'b0;
        end else begin
            if (bus.req_ready != '0) begin
                check("req_ready_onehot", 32'($onehot(bus.req_ready)), 32'd1);
                acc_q.push_back(cyc);
            end
            if (bus.rsp_valid && !prev_valid) begin
                if (acc_q.size() == 0) fail("rsp_valid_without_accept");
                else check("latency", cyc - acc_q.pop_front(), 32'd2);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) fail("unexpected_response");
                else check("rsp", {bus.rsp_id, bus.rsp_gt, bus.rsp_eq, bus.rsp_lt}, sb.pop_front());
            end
            prev_valid <= bus.rsp_valid;
        end
    end

    task automatic reset_check();
        check("reset_outputs", {bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_gt,
                                bus.rsp_eq, bus.rsp_lt, bus.busy}, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.req_valid = '0;
        #1 reset_check();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
    endtask

    task automatic push(input int id, input logic gt, input logic eq, input logic lt);
        sb.push_back({2'(id), gt, eq, lt});
    endtask

    task automatic wait_grant(input int idx);
        bit got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                got = 1;
                gcyc = cyc;
                check("grant", 32'(bus.req_ready), 32'(1 << idx));
            end
        end
        if (!got) fail("grant_timeout");
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            done = !bus.busy && !bus.rsp_valid && sb.size() == 0;
        end
        if (!done) fail("idle_timeout");
    endtask

    task automatic issue(input int idx, input logic [7:0] a, input logic [7:0] b,
                         input logic gt, input logic eq, input logic lt);
        @(posedge clk); #1;
        set_op(idx, a, b);
        push(idx, gt, eq, lt);
        bus.req_valid = 4'(1 << idx);
        wait_grant(idx);
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_idle();
    endtask

    initial begin
        int order[6] = '{0, 1, 2, 3, 0, 2};
        int prev = 0;
        bit seen;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1 reset_check();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // single request, then sign handling and equality on rotating requesters
        issue(0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0);
`ifdef COMPARATOR_ARBITER_SIGNED_EN
        issue(1, 8'h80, 8'h01, 1'b0, 1'b0, 1'b1);
`else
        issue(1, 8'h80, 8'h01, 1'b1, 1'b0, 1'b0);
`endif
        issue(2, 8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0);

        // backpressure on requester 3 with requester 0 pending
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        set_op(3, 8'h03, 8'h07);
        push(3, 1'b0, 1'b0, 1'b1);
        bus.req_valid = 4'b1000;
        wait_grant(3);
        @(posedge clk); #1;
        set_op(0, 8'h20, 8'h10);
        push(0, 1'b1, 1'b0, 1'b0);
        bus.req_valid = 4'b0001;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus.rsp_valid;
        end
        if (!seen) fail("rsp_valid_timeout");
        repeat (5) begin
            @(negedge clk);
            check("hold_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_gt, bus.rsp_eq, bus.rsp_lt}, 32'b1_11_001);
            check("hold_no_grant", 32'(bus.req_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("idle_after_release", {bus.busy, bus.rsp_valid}, 32'd0);
        check("pending_grant", 32'(bus.req_ready), 32'b0001);
        wait_grant(0);
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_idle();

        // round robin from reset, then wrap-around with 0101
        do_reset();
        @(posedge clk); #1;
        set_op(0, 8'h20, 8'h10);
        set_op(1, 8'h11, 8'h22);
        set_op(2, 8'h5A, 8'h5A);
        set_op(3, 8'hFF, 8'hFE);
        push(0, 1'b1, 1'b0, 1'b0);
        push(1, 1'b0, 1'b0, 1'b1);
        push(2, 1'b0, 1'b1, 1'b0);
        push(3, 1'b1, 1'b0, 1'b0);
        push(0, 1'b1, 1'b0, 1'b0);
        push(2, 1'b0, 1'b1, 1'b0);
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            wait_grant(order[k]);
            if (k > 0) check("grant_spacing", gcyc - prev, 32'd3);
            prev = gcyc;
            if (k == 3) begin
                @(posedge clk); #1;
                bus.req_valid = 4'b0101;
            end
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_idle();

        // reset while in COMPARE discards the result and rewinds rr_ptr
        @(posedge clk); #1;
        set_op(1, 8'h11, 8'h22);
        set_op(3, 8'h40, 8'h40);
        bus.req_valid = 4'b0010;
        wait_grant(1);
        @(posedge clk); #1;
        check("busy_in_compare", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        bus.req_valid = '0;
        #1 reset_check();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("no_rsp_after_reset", 32'(bus.rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        push(1, 1'b0, 1'b0, 1'b1);
        bus.req_valid = 4'b1010;
        wait_grant(1);
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_idle();

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/comparator_arbiter.md
COMPARATOR_ARBITER -- requirements
Module: comparator_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the comparator (2..16).
REQ-002 Parameter WIDTH, default 8: operand width in bits.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester request valid.
REQ-006 req_a  input  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 req_b  input  NUM_REQ*WIDTH  operand B; same packing as req_a.
REQ-008 req_ready  output  NUM_REQ  one-hot grant/accept; at most one bit high per cycle.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  downstream accepts result.
REQ-011 rsp_id  output  $clog2(NUM_REQ)  index of the requester that owns the result.
REQ-012 rsp_gt, rsp_eq, rsp_lt  output  1 each  A>B, A==B, A<B; exactly one high while rsp_valid.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states IDLE, COMPARE, RESPOND; encoding is implementation choice.
REQ-015 IDLE: if any req_valid is high, req_ready is asserted combinationally for the winner; the request is accepted, operands and id are captured, and the FSM enters COMPARE.
REQ-016 Winner is the first index with req_valid high, searching from rr_ptr upward with wrap-around past NUM_REQ-1 to 0.
REQ-017 COMPARE: lasts exactly one cycle; compare on captured operands; flags registered; FSM enters RESPOND.
REQ-018 RESPOND: rsp_valid high; rsp_id and flags held stable until rsp_valid && rsp_ready.
REQ-019 On response handshake: FSM returns to IDLE; rr_ptr becomes (granted id + 1) mod NUM_REQ.
REQ-020 req_ready is all-zero in COMPARE and RESPOND; requests arriving then stay pending; requesters hold valid and operands until accepted.
REQ-021 Latency: accept at cycle T gives rsp_valid at T+2; max throughput one result per 3 cycles with rsp_ready tied high.
REQ-022 Dropping req_valid while not granted is legal; no state change results.
REQ-023 Outputs are registered except req_ready, which is decoded from state, rr_ptr and req_valid.

Reset
REQ-024 rst_n low asynchronously forces IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_gt=rsp_eq=rsp_lt=0, busy=0, req_ready=0.
REQ-025 Reset during COMPARE or RESPOND discards the in-flight result; no rsp_valid follows after release.
REQ-026 First arbitration after reset release starts from index 0.

Configuration
REQ-027 Macro COMPARATOR_ARBITER_SIGNED_EN defined: operands compare as two's-complement signed.
REQ-028 Macro undefined: operands compare as unsigned; port list and timing are identical in both builds.

Verification
REQ-029 Single request: req_valid=0001, A0=0x20, B0=0x10 -> req_ready=0001 at T; rsp_valid at T+2, rsp_id=0, rsp_gt=1.
REQ-030 Round-robin: all four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0, each grant 3 cycles apart.
REQ-031 Backpressure: rsp_ready=0 for 5 cycles in RESPOND -> rsp_valid, rsp_id, flags stable; req_ready=0000 throughout; release -> IDLE next cycle.
REQ-032 Sign handling: A=0x80, B=0x01 -> rsp_lt=1 with COMPARATOR_ARBITER_SIGNED_EN defined, rsp_gt=1 without; A=B=0x5A -> rsp_eq=1.
REQ-033 Reset mid-operation: assert rst_n low in COMPARE -> outputs at reset values immediately; after release, no response; next grant searches from index 0.
REQ-034 Wrap-around: last grant to index 3, then req_valid=0101 -> next grant index 0; following grant index 2.
